// File: rtl/bcd_ser_if.sv
// Handshake bundle for bcd_digit_serializer: packed-BCD word in, one digit per beat out.
// master = word source / digit sink, slave = the serializer.
interface bcd_ser_if #(
    parameter int DIGITS = 11,
    parameter int OUT_W  = 8,
    parameter int CNT_W  = ($clog2(DIGITS + 1) > 1) ? $clog2(DIGITS + 1) : 1
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_data;
    logic [CNT_W-1:0]      in_ndig;
    logic                  in_msb;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_digit;
    logic [CNT_W-1:0]      out_idx;
    logic                  out_last;
    logic                  out_err;
    logic                  word_err;
    logic                  busy;

    modport master (
        output in_valid, in_data, in_ndig, in_msb, out_ready,
        input  in_ready, out_valid, out_digit, out_idx, out_last, out_err, word_err, busy
    );

    modport slave (
        input  in_valid, in_data, in_ndig, in_msb, out_ready,
        output in_ready, out_valid, out_digit, out_idx, out_last, out_err, word_err, busy
    );
endinterface

// File: rtl/bcd_digit_serializer.sv
// Packed-BCD word to digit-stream serializer with selectable order and per-word digit count.
// Optional macro BCD_SER_ASCII_EN: emit ASCII '0'..'9' ('?' for invalid nibbles) instead of binary.
module bcd_digit_serializer #(
    parameter int DIGITS = 11,
    parameter int OUT_W  = 8
) (
    input logic      clk,
    input logic      rst,
    bcd_ser_if.slave bus
);
    localparam int CNT_W = ($clog2(DIGITS + 1) > 1) ? $clog2(DIGITS + 1) : 1;

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e                 state_q, state_d;
    logic [DIGITS-1:0][3:0] data_q, data_d;
    logic [CNT_W-1:0]       ndig_q, ndig_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   msb_q, msb_d;
    logic                   err_q, err_d;

    logic [CNT_W-1:0] ndig_in;
    logic [CNT_W-1:0] idx;
    logic [3:0]       nib;
    logic             nib_err;
    logic             last;
    logic             out_valid;
    logic             fire;
    logic             accept;
    logic [OUT_W-1:0] digit;

    assign ndig_in = (bus.in_ndig == '0 || bus.in_ndig > CNT_W'(DIGITS)) ? CNT_W'(DIGITS)
                                                                        : bus.in_ndig;
    // cnt_q counts beats already emitted; MSB-first mirrors it inside the active window
    assign idx     = msb_q ? (ndig_q - CNT_W'(1) - cnt_q) : cnt_q;
    assign nib     = data_q[idx];
    assign nib_err = nib > 4'd9;
    assign last    = (cnt_q == ndig_q - CNT_W'(1));

    assign out_valid = (state_q == SHIFT);
    assign fire      = out_valid && bus.out_ready;
    assign accept    = bus.in_valid && bus.in_ready;

`ifdef BCD_SER_ASCII_EN
    logic [7:0] asc;
    assign asc   = nib_err ? 8'h3F : (8'h30 + {4'h0, nib});
    assign digit = OUT_W'(asc);
`else
    assign digit = OUT_W'(nib);
`endif

    assign bus.in_ready  = !rst && ((state_q == IDLE) || (fire && last));
    assign bus.out_valid = out_valid;
    assign bus.out_digit = out_valid ? digit : '0;
    assign bus.out_idx   = out_valid ? idx : '0;
    assign bus.out_last  = out_valid && last;
    assign bus.out_err   = out_valid && nib_err;
    assign bus.word_err  = out_valid && last && (err_q || nib_err);
    assign bus.busy      = out_valid;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ndig_d  = ndig_q;
        cnt_d   = cnt_q;
        msb_d   = msb_q;
        err_d   = err_q;
        if (accept) begin
            // covers both IDLE loads and a reload on the last-beat edge
            state_d = SHIFT;
            data_d  = bus.in_data;
            ndig_d  = ndig_in;
            msb_d   = bus.in_msb;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else if (fire) begin
            if (last) begin
                state_d = IDLE;
                cnt_d   = '0;
                err_d   = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                err_d = err_q || nib_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            ndig_q  <= '0;
            cnt_q   <= '0;
            msb_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ndig_q  <= ndig_d;
            cnt_q   <= cnt_d;
            msb_q   <= msb_d;
            err_q   <= err_d;
        end
    end
endmodule
